// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot / auto-reload expiry and a sticky irq.
// Define TIMER_MISS_COUNT_EN to add a saturating count of expiries missed while irq was pending.
module countdown_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             periodic,
  input  logic             irq_ack,
  output logic [WIDTH-1:0] count,
  output logic             irq,
  output logic             busy
`ifdef TIMER_MISS_COUNT_EN
  ,
  output logic [3:0]       miss_count
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             irq_q, irq_d;
  logic             expire;

  // Expiry is the enabled edge that finds the count already at zero; load overrides it.
  assign expire = (state_q == RUN) && enable && !load && (count_q == '0);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    if (load) begin
      state_d  = RUN;
      count_d  = load_value;
      reload_d = load_value;
    end else if (state_q == RUN && enable) begin
      if (count_q != '0) begin
        count_d = count_q - WIDTH'(1);
      end else if (periodic) begin
        count_d = reload_q;
      end else begin
        state_d = DONE;
      end
    end
  end

  // Setting on expiry wins over a simultaneous acknowledge.
  always_comb begin
    irq_d = irq_q;
    if (expire) begin
      irq_d = 1'b1;
    end else if (irq_ack) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      irq_q    <= irq_d;
    end
  end

  assign count = count_q;
  assign irq   = irq_q;
  assign busy  = (state_q == RUN);

`ifdef TIMER_MISS_COUNT_EN
  logic [3:0] miss_q, miss_d;

  // An acknowledge always empties the counter, even if a miss lands on the same edge.
  always_comb begin
    miss_d = miss_q;
    if (irq_ack) begin
      miss_d = 4'd0;
    end else if (expire && irq_q && miss_q != 4'd15) begin
      miss_d = miss_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_q <= 4'd0;
    end else begin
      miss_q <= miss_d;
    end
  end

  assign miss_count = miss_q;
`endif

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have one parameter, WIDTH, default 8: the bit width of the count, reload value and load value.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: one clock; reset is asynchronous and active-high.
REQ-004 The block SHALL have port enable, input, 1 bit: decrement qualifier, evaluated in RUN only.
REQ-005 The block SHALL have port load, input, 1 bit: load strobe, sampled each rising edge.
REQ-006 The block SHALL have port load_value, input, WIDTH bits: start and reload value, captured when load=1.
REQ-007 The block SHALL have port periodic, input, 1 bit: expiry mode, 1 = auto-reload, 0 = one-shot; sampled at the expiry edge.
REQ-008 The block SHALL have port irq_ack, input, 1 bit: a one-cycle pulse that clears a pending irq.
REQ-009 The block SHALL have port count, output, WIDTH bits: the current registered count value.
REQ-010 The block SHALL have port irq, output, 1 bit: the registered, sticky expiry interrupt.
REQ-011 The block SHALL have port busy, output, 1 bit: high exactly when the state is RUN.

Function
REQ-012 The state machine SHALL have three states: IDLE, RUN and DONE.
REQ-013 load=1 in any state SHALL set count and reload_reg to load_value and move to RUN at that edge; load takes priority over enable and over expiry.
REQ-014 In RUN with enable=1, load=0 and count>0, count SHALL decrement by 1 per edge.
REQ-015 In RUN with enable=0, count and state SHALL hold.
REQ-016 Expiry SHALL occur when the state is RUN, enable=1, load=0 and count==0; at that edge irq SHALL be set to 1.
REQ-017 At expiry with periodic=1, count SHALL be set to reload_reg and the state SHALL stay RUN, giving a period of reload_reg+1 enabled cycles.
REQ-018 At expiry with periodic=0, count SHALL remain 0 and the state SHALL move to DONE.
REQ-019 In IDLE and DONE, enable SHALL be ignored and count SHALL hold.
REQ-020 Loading load_value=0 SHALL enter RUN with count 0, so the next enabled edge expires.
REQ-021 Arithmetic SHALL be unsigned modulo 2^WIDTH, with no underflow past 0; wrap-around occurs only through reload.
REQ-022 irq_ack=1 SHALL clear irq at the next edge, except that when expiry coincides with irq_ack, set wins and irq stays 1.
REQ-023 irq_ack while irq=0 SHALL have no effect.
REQ-024 load SHALL NOT modify irq.
REQ-025 An expiry while irq is already 1 SHALL leave irq at 1.

Reset
REQ-026 While rst=1, immediately and regardless of clk, the block SHALL force: state IDLE, count 0, reload_reg 0, irq 0, busy 0.
REQ-027 Assertion of rst mid-count SHALL abort the count without raising irq.
REQ-028 After rst deasserts, the first load SHALL behave as from power-up.

Configuration
REQ-029 With macro TIMER_MISS_COUNT_EN defined, the block SHALL add output miss_count, 4 bits: a count of expiries occurring while irq is already 1, saturating at 15.
REQ-030 miss_count SHALL clear on rst and on irq_ack.
REQ-031 If irq_ack coincides with a missed expiry, miss_count SHALL go to 0.
REQ-032 Without TIMER_MISS_COUNT_EN, the miss_count port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 Reset/one-shot: release rst; load 8'h03, periodic=0, enable=1 -> count 3,2,1,0; irq=1 and busy=0 on the next edge; count stays 0.
REQ-034 Periodic: load 8'h02, periodic=1, enable held -> count 2,1,0,2,1,0...; irq set at the first expiry; irq_ack clears it; irq sets again 3 cycles later.
REQ-035 Enable gating: load 8'h05, toggle enable 1/0 each cycle -> count decrements only on enable=1 edges; expiry after 6 enabled edges.
REQ-036 Simultaneous events: irq_ack on the expiry edge -> irq remains 1; load on the expiry edge -> count=load_value and irq unchanged.
REQ-037 Mid-run reset: load 8'hFA, enable=1, assert rst at count 8'hF5 -> count 0, busy 0, irq 0 immediately.
REQ-038 With TIMER_MISS_COUNT_EN: periodic reload 0, no ack for 20 cycles -> miss_count saturates at 15; irq_ack -> miss_count 0.
